// File: rtl/img_pkg.sv
// Shared image geometry and the streamer state encoding.
// Used by image_byte_streamer and its checksum helper.
package img_pkg;

  localparam int IMG_WIDTH     = 30;
  localparam int IMG_HEIGHT    = 30;
  localparam int TOTAL_BITS    = 904;
  localparam int IMG_BYTE_SIZE = 113;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STREAM,
    DONE
  } stream_state_t;

endpackage

// File: rtl/xor_checksum.sv
// 8-bit running XOR of accepted bytes, cleared per stream.
// Only built when IMG_STREAM_CHECKSUM_EN is defined.
module xor_checksum (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] sum
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum <= '0;
    end else if (clear) begin
      sum <= '0;
    end else if (en) begin
      sum <= sum ^ din;
    end
  end

endmodule

// File: rtl/image_byte_streamer.sv
// Streams a snapshot of the 904-bit image as 113 bytes, LSB first.
// IMG_STREAM_CHECKSUM_EN appends an XOR checksum byte (114 bytes).
module image_byte_streamer #(
  parameter int IMG_BYTE_SIZE = img_pkg::IMG_BYTE_SIZE,
  parameter int TOTAL_BITS    = img_pkg::TOTAL_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [TOTAL_BITS-1:0] img_in,
  output logic [7:0]            data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic [6:0]            byte_index,
  output logic                  busy,
  output logic                  done
);

  import img_pkg::*;

`ifdef IMG_STREAM_CHECKSUM_EN
  localparam logic [6:0] LAST_IDX = 7'(IMG_BYTE_SIZE);
`else
  localparam logic [6:0] LAST_IDX = 7'(IMG_BYTE_SIZE - 1);
`endif

  stream_state_t state_q, state_d;

  logic [TOTAL_BITS-1:0] snap_q;
  logic [6:0] idx_q, idx_d, nidx;
  logic [9:0] noff;
  logic [7:0] data_q, data_d, nb;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       snap_ld;
  logic       xfer;

`ifdef IMG_STREAM_CHECKSUM_EN
  logic       csum_clr;
  logic       csum_en;
  logic [7:0] csum;

  xor_checksum u_csum (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (csum_clr),
    .en    (csum_en),
    .din   (data_q),
    .sum   (csum)
  );
`endif

  assign xfer = valid_q & data_ready;
  assign nidx = idx_q + 7'd1;
  assign noff = {nidx, 3'b000};

  // Byte that follows the one now on data_out
  always_comb begin
    nb = snap_q[noff +: 8];
`ifdef IMG_STREAM_CHECKSUM_EN
    if (nidx == 7'(IMG_BYTE_SIZE)) begin
      nb = csum ^ data_q;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    snap_ld = 1'b0;
`ifdef IMG_STREAM_CHECKSUM_EN
    csum_clr = 1'b0;
    csum_en  = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        idx_d   = '0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        if (start) begin
          state_d = LOAD;
          busy_d  = 1'b1;
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          valid_d = 1'b0;
        end else begin
          state_d = STREAM;
          snap_ld = 1'b1;
          idx_d   = '0;
          data_d  = img_in[7:0];
          valid_d = 1'b1;
`ifdef IMG_STREAM_CHECKSUM_EN
          csum_clr = 1'b1;
`endif
        end
      end
      STREAM: begin
        if (abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          valid_d = 1'b0;
          idx_d   = '0;
        end else if (xfer) begin
`ifdef IMG_STREAM_CHECKSUM_EN
          csum_en = (idx_q != LAST_IDX);
`endif
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            idx_d   = '0;
          end else begin
            idx_d  = nidx;
            data_d = nb;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      snap_q <= '0;
    end else if (snap_ld) begin
      snap_q <= img_in;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign byte_index = idx_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_image_byte_streamer.sv
// Randomized self-checking bench for image_byte_streamer.
// Honours IMG_STREAM_CHECKSUM_EN when the bench is built with it.
module tb_image_byte_streamer;

  localparam int NB = 113;
`ifdef IMG_STREAM_CHECKSUM_EN
  localparam int SLEN = NB + 1;
`else
  localparam int SLEN = NB;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         abort;
  logic [903:0] img_in;
  logic [7:0]   data_out;
  logic         data_valid;
  logic         data_ready;
  logic [6:0]   byte_index;
  logic         busy;
  logic         done;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] img_ref [NB];
  logic [7:0] got_d [$];
  int         got_i [$];
  int         got_t [$];
  int         done_cnt;
  int         done_t;
  int         stall_err;
  logic       busy1;

  image_byte_streamer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .img_in     (img_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .byte_index (byte_index),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_img();
    for (int k = 0; k < NB; k++) img_in[k*8 +: 8] = img_ref[k];
  endtask

  // Reference stream: image bytes in order, then optional XOR of all of them
  function automatic logic [7:0] exp_byte(input int k);
    logic [7:0] x;
    if (k < NB) return img_ref[k];
    x = 8'h00;
    for (int j = 0; j < NB; j++) x = x ^ img_ref[j];
    return x;
  endfunction

  // Run one stream from a start pulse, logging transfers by edge number.
  task automatic capture(input bit rnd, input int mutate_at, input int poke_at);
    int t;
    logic pv, pr;
    logic [7:0] pd;
    logic [6:0] pi;
    got_d.delete();
    got_i.delete();
    got_t.delete();
    done_cnt = 0;
    done_t = -1;
    stall_err = 0;
    abort = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    t = 0;
    busy1 = busy;
    pv = 1'b0;
    pr = 1'b0;
    pd = '0;
    pi = '0;
    while (t < 1000) begin
      if (done === 1'b1) begin
        done_cnt++;
        if (done_t < 0) done_t = t;
      end
      if (done_t >= 0 && t > done_t + 4) break;
      if (pv && !pr) begin
        if (!(data_valid === 1'b1 && data_out === pd && byte_index === pi))
          stall_err++;
      end
      if (t == mutate_at) img_in = '1;
      start = (t == poke_at);
      data_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      pv = data_valid;
      pr = data_ready;
      pd = data_out;
      pi = byte_index;
      tick();
      t++;
      if (pv === 1'b1 && pr === 1'b1) begin
        got_d.push_back(pd);
        got_i.push_back(int'(pi));
        got_t.push_back(t);
      end
    end
    start = 1'b0;
    data_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    data_ready = 1'b0;
    img_in = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      n_cmp++;
      if ({data_out, data_valid, byte_index, busy, done} !== 18'h0) begin
        n_err++;
        $display("FAIL reset_idle cyc%0d: got dout=%h v=%b idx=%0d busy=%b done=%b, want all 0",
                 c, data_out, data_valid, byte_index, busy, done);
      end
      tick();
    end
  endtask

  task automatic test_basic();
    int last;
    for (int k = 0; k < NB; k++) img_ref[k] = 8'(k);
    load_img();
    capture(1'b0, -1, -1);
    n_cmp++;
    if (busy1 !== 1'b1) begin
      n_err++;
      $display("FAIL basic_busy_rise: got %b want 1", busy1);
    end
    n_cmp++;
    if (got_d.size() != SLEN) begin
      n_err++;
      $display("FAIL basic_count: got %0d want %0d", got_d.size(), SLEN);
    end
    for (int i = 0; i < got_d.size() && i < SLEN; i++) begin
      n_cmp++;
      if (got_d[i] !== exp_byte(i) || got_i[i] != i || got_t[i] != 2 + i) begin
        n_err++;
        $display("FAIL basic_byte%0d: got %h idx%0d edge%0d want %h idx%0d edge%0d",
                 i, got_d[i], got_i[i], got_t[i], exp_byte(i), i, 2 + i);
      end
    end
    last = 1 + SLEN;
    n_cmp++;
    if (done_cnt != 1 || done_t != last) begin
      n_err++;
      $display("FAIL basic_done: got %0d pulses at %0d want 1 at %0d",
               done_cnt, done_t, last);
    end
`ifdef IMG_STREAM_CHECKSUM_EN
    n_cmp++;
    if (got_d.size() == SLEN && got_d[SLEN-1] !== 8'h70) begin
      n_err++;
      $display("FAIL checksum_byte: got %h want 70", got_d[SLEN-1]);
    end
`endif
  endtask

  task automatic test_stall();
    for (int k = 0; k < NB; k++) img_ref[k] = 8'(k);
    load_img();
    capture(1'b1, -1, -1);
    n_cmp++;
    if (stall_err != 0) begin
      n_err++;
      $display("FAIL stall_hold: got %0d unstable stalls want 0", stall_err);
    end
    n_cmp++;
    if (got_d.size() != SLEN || done_cnt != 1) begin
      n_err++;
      $display("FAIL stall_count: got %0d bytes %0d done want %0d bytes 1 done",
               got_d.size(), done_cnt, SLEN);
    end
    for (int i = 0; i < got_d.size() && i < SLEN; i++) begin
      n_cmp++;
      if (got_d[i] !== exp_byte(i) || got_i[i] != i) begin
        n_err++;
        $display("FAIL stall_byte%0d: got %h idx%0d want %h idx%0d",
                 i, got_d[i], got_i[i], exp_byte(i), i);
      end
    end
  endtask

  task automatic test_snapshot();
    int bad;
    for (int k = 0; k < NB; k++) img_ref[k] = 8'($urandom_range(0, 254));
    load_img();
    capture(1'b1, 1, -1);
    bad = 0;
    for (int i = 0; i < got_d.size() && i < SLEN; i++)
      if (got_d[i] !== exp_byte(i)) bad++;
    n_cmp++;
    if (bad != 0 || got_d.size() != SLEN) begin
      n_err++;
      $display("FAIL snapshot: got %0d bad of %0d bytes want 0 bad of %0d",
               bad, got_d.size(), SLEN);
    end
  endtask

  task automatic test_abort();
    bit hit;
    int dn;
    for (int k = 0; k < NB; k++) img_ref[k] = 8'(k);
    load_img();
    data_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    hit = 0;
    for (int c = 0; c < 300 && !hit; c++) begin
      if (data_valid === 1'b1 && byte_index === 7'd50) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        hit = 1;
      end else begin
        tick();
      end
    end
    n_cmp++;
    if (!hit || data_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL abort_stop: got hit=%0d v=%b busy=%b want 1 0 0",
               hit, data_valid, busy);
    end
    dn = 0;
    for (int c = 0; c < 5; c++) begin
      if (done === 1'b1 || data_valid === 1'b1) dn++;
      tick();
    end
    n_cmp++;
    if (dn != 0) begin
      n_err++;
      $display("FAIL abort_quiet: got %0d done/valid cycles want 0", dn);
    end
    capture(1'b0, -1, -1);
    n_cmp++;
    if (got_d.size() != SLEN || got_d[0] !== 8'h00 || got_i[0] != 0) begin
      n_err++;
      $display("FAIL abort_restart: got %0d bytes first %h want %0d first 00",
               got_d.size(), got_d.size() ? got_d[0] : 8'hxx, SLEN);
    end
  endtask

  task automatic test_start_ignored();
    for (int k = 0; k < NB; k++) img_ref[k] = 8'(k);
    load_img();
    capture(1'b0, -1, 30);
    n_cmp++;
    if (got_d.size() != SLEN || done_cnt != 1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL start_ignored: got %0d bytes %0d done busy=%b want %0d 1 0",
               got_d.size(), done_cnt, busy, SLEN);
    end
  endtask

  task automatic test_back_to_back();
    int rises [$];
    logic pb;
    int t;
    for (int k = 0; k < NB; k++) img_ref[k] = 8'($urandom_range(0, 255));
    load_img();
    data_ready = 1'b1;
    start = 1'b1;
    pb = busy;
    t = 0;
    while (t < 400 && rises.size() < 2) begin
      tick();
      t++;
      if (busy === 1'b1 && pb !== 1'b1) rises.push_back(t);
      pb = busy;
    end
    start = 1'b0;
    n_cmp++;
    if (rises.size() != 2 || rises[1] - rises[0] != SLEN + 3) begin
      n_err++;
      $display("FAIL back_to_back: got %0d rises period %0d want 2 period %0d",
               rises.size(), rises.size() == 2 ? rises[1] - rises[0] : -1, SLEN + 3);
    end
    t = 0;
    while (t < 400 && done !== 1'b1) begin
      tick();
      t++;
    end
    n_cmp++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_drain: got no done within 400 cycles want done");
    end
    repeat (3) tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_snapshot();
    test_abort();
    test_start_ignored();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
